// File: rtl/program_loader.sv
// program_loader: fills instruction memory from a byte stream. Every 4 bytes are packed MSB first
// into one 32-bit word, which is written at consecutive addresses from 0. Loading stops after the
// HLT word (opcode 6'b111111) is written, and the core is then released through cpu_run.
// Optional feature: define PROGRAM_LOADER_OPCODE_CHECK_EN to reject words whose opcode is not in
// the legal set. A rejected word is not written and the loader goes to ERROR with err_code 10.
module program_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   word_count,
   output logic              cpu_run
);

   typedef enum logic [2:0] {StIdle, StLoad, StWrite, StDone, StError} state_e;

   state_e          state_q, state_d;
   logic [31:0]     word_q, word_d;
   logic [1:0]      idx_q, idx_d;
   logic [ADDR_W:0] count_q, count_d;
   logic [1:0]      err_q, err_d;

   logic [5:0] opcode;
   logic       is_hlt;
   logic       op_illegal;

   assign opcode = word_q[31:26];
   assign is_hlt = (opcode == 6'b111111);

`ifdef PROGRAM_LOADER_OPCODE_CHECK_EN
   // Holes in the opcode map; HLT (111111) is legal.
   always_comb begin
      op_illegal = 1'b0;
      if (opcode == 6'b011011 || opcode == 6'b011100 || opcode == 6'b100011 ||
          (opcode >= 6'b100111 && opcode <= 6'b111110)) begin
         op_illegal = 1'b1;
      end
   end
`else
   assign op_illegal = 1'b0;
`endif

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         word_q  <= '0;
         idx_q   <= '0;
         count_q <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: byte packing, the write decision and restart handling.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      count_d = count_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               state_d = StLoad;
               word_d  = '0;
               idx_d   = '0;
               count_d = '0;
               err_d   = '0;
            end
         end
         StLoad: begin
            if (in_valid) begin
               word_d = {word_q[23:0], in_data};
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = StWrite;
            end
         end
         StWrite: begin
            if (op_illegal) begin
               state_d = StError;
               err_d   = 2'b10;
            end else begin
               count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
               if (is_hlt) begin
                  state_d = StDone;
               // The last address has just been used and no HLT was seen.
               end else if (&count_q[ADDR_W-1:0]) begin
                  state_d = StError;
                  err_d   = 2'b01;
               end else begin
                  state_d = StLoad;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from registered state only.
   always_comb begin
      in_ready   = (state_q == StLoad);
      im_we      = (state_q == StWrite) && !op_illegal;
      im_addr    = count_q[ADDR_W-1:0];
      im_wdata   = word_q;
      busy       = (state_q == StLoad) || (state_q == StWrite);
      done       = (state_q == StDone);
      error      = (state_q == StError);
      err_code   = err_q;
      word_count = count_q;
      cpu_run    = (state_q == StDone);
   end

endmodule
